// File: rtl/clock_pkg.sv
// Shared types and limits for the clock block and its programmatic setter.
package clock_pkg;
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] HOURS = HOUR_W'(24);
  localparam logic [MIN_W-1:0]  MINS  = MIN_W'(60);
  localparam logic [SEC_W-1:0]  SECS  = SEC_W'(60);

  typedef enum logic [1:0] {MODE_RUN, MODE_SEC, MODE_MIN, MODE_HOUR} clk_mode_e;
  typedef enum logic [1:0] {BTN_SET_TIME, BTN_SEC, BTN_MIN, BTN_HOUR} btn_e;
  typedef enum logic [1:0] {ST_IDLE, ST_SET, ST_RETURN} setter_state_e;

  function automatic clk_mode_e next_mode(input clk_mode_e m);
    case (m)
      MODE_RUN:  next_mode = MODE_SEC;
      MODE_SEC:  next_mode = MODE_MIN;
      MODE_MIN:  next_mode = MODE_HOUR;
      default:   next_mode = MODE_RUN;
    endcase
  endfunction

  function automatic btn_e field_btn(input clk_mode_e m);
    case (m)
      MODE_SEC:  field_btn = BTN_SEC;
      MODE_MIN:  field_btn = BTN_MIN;
      MODE_HOUR: field_btn = BTN_HOUR;
      default:   field_btn = BTN_SET_TIME;
    endcase
  endfunction
endpackage

// File: rtl/clock_setter_if.sv
// Host handshake plus clock button/feedback bundle for clock_setter.
interface clock_setter_if;
  import clock_pkg::*;

  logic              start;
  logic [HOUR_W-1:0] tgt_hour;
  logic [MIN_W-1:0]  tgt_minute;
  logic [SEC_W-1:0]  tgt_second;
  logic [HOUR_W-1:0] cur_hour;
  logic [MIN_W-1:0]  cur_minute;
  logic [SEC_W-1:0]  cur_second;
  logic              set_time;
  logic              secondSet;
  logic              minuteSet;
  logic              hourSet;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, tgt_hour, tgt_minute, tgt_second, cur_hour, cur_minute, cur_second,
    input  set_time, secondSet, minuteSet, hourSet, busy, done, err
  );

  modport slave (
    input  start, tgt_hour, tgt_minute, tgt_second, cur_hour, cur_minute, cur_second,
    output set_time, secondSet, minuteSet, hourSet, busy, done, err
  );
endinterface

// File: rtl/clock_setter_button_pulser.sv
// One-cycle pulse generator; ready returns after a gap-only or gap+settle wait.
module button_pulser #(
  parameter int PULSE_GAP = 1,
  parameter int SETTLE    = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic short_i,
  output logic pulse_o,
  output logic ready_o
);
  localparam int LONG_LEN = PULSE_GAP + SETTLE;
  localparam int CNT_W    = $clog2(LONG_LEN + 2);

  logic             pulse_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;

  // cnt_q holds the remaining wait cycles; ready follows the cycle it hits zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (!busy_q) begin
      if (req_i) begin
        pulse_q <= 1'b1;
        busy_q  <= 1'b1;
        cnt_q   <= short_i ? CNT_W'(PULSE_GAP) : CNT_W'(LONG_LEN);
      end
    end else begin
      pulse_q <= 1'b0;
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - 1'b1;
    end
  end

  assign pulse_o = pulse_q;
  assign ready_o = !busy_q;
endmodule

// File: rtl/clock_setter.sv
// Drives the clock's set buttons until its feedback matches a requested time.
module clock_setter
  import clock_pkg::*;
#(
  parameter int PULSE_GAP = 1,
  parameter int SETTLE    = 2,
  parameter int MAX_STEPS = 63
) (
  input  logic          clk,
  input  logic          reset,
  clock_setter_if.slave bus
);
  localparam int STEP_W = $clog2(MAX_STEPS + 1);

  setter_state_e     state_q;
  clk_mode_e         mode_q;
  btn_e              sel_q;
  logic [STEP_W-1:0] step_q;
  logic [HOUR_W-1:0] tgt_hour_q;
  logic [MIN_W-1:0]  tgt_minute_q;
  logic [SEC_W-1:0]  tgt_second_q;
  logic              busy_q, done_q, err_q, aborting_q;

  logic pulse, ready, req, req_short;
  btn_e req_btn;
  logic tgt_valid, field_match, budget_out, accept, cmp_now, ret_now, ret_end;

  button_pulser #(.PULSE_GAP(PULSE_GAP), .SETTLE(SETTLE)) u_pulser (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req),
    .short_i (req_short),
    .pulse_o (pulse),
    .ready_o (ready)
  );

  // mode_q tracks the clock's mode; both normal completion and abort unwind via ST_RETURN
  always_comb begin
    tgt_valid = (bus.tgt_hour < HOURS) && (bus.tgt_minute < MINS) && (bus.tgt_second < SECS);
    field_match = 1'b0;
    case (mode_q)
      MODE_SEC:  field_match = (bus.cur_second == tgt_second_q);
      MODE_MIN:  field_match = (bus.cur_minute == tgt_minute_q);
      MODE_HOUR: field_match = (bus.cur_hour   == tgt_hour_q);
      default:   field_match = 1'b0;
    endcase
    budget_out = (step_q == STEP_W'(MAX_STEPS));
    accept     = (state_q == ST_IDLE) && bus.start && tgt_valid;
    cmp_now    = (state_q == ST_SET) && ready;
    ret_now    = (state_q == ST_RETURN) && ready;
    ret_end    = ret_now && (mode_q == MODE_RUN);
    req        = accept || cmp_now || (ret_now && !ret_end);
    req_short  = ret_now || (cmp_now && (field_match ? (mode_q == MODE_HOUR) : budget_out));
    req_btn    = (cmp_now && !field_match && !budget_out) ? field_btn(mode_q) : BTN_SET_TIME;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_RUN;
      sel_q        <= BTN_SET_TIME;
      step_q       <= '0;
      tgt_hour_q   <= '0;
      tgt_minute_q <= '0;
      tgt_second_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      aborting_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (req) sel_q <= req_btn;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (!tgt_valid) begin
              err_q <= 1'b1;
            end else begin
              tgt_hour_q   <= bus.tgt_hour;
              tgt_minute_q <= bus.tgt_minute;
              tgt_second_q <= bus.tgt_second;
              busy_q       <= 1'b1;
              mode_q       <= MODE_SEC;
              step_q       <= '0;
              aborting_q   <= 1'b0;
              state_q      <= ST_SET;
            end
          end
        end
        ST_SET: begin
          if (ready) begin
            if (field_match || budget_out) begin
              mode_q <= next_mode(mode_q);
              step_q <= '0;
              if (!field_match || (mode_q == MODE_HOUR)) begin
                aborting_q <= !field_match;
                state_q    <= ST_RETURN;
              end
            end else begin
              step_q <= step_q + 1'b1;
            end
          end
        end
        ST_RETURN: begin
          if (ready) begin
            if (mode_q == MODE_RUN) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
              if (aborting_q) err_q  <= 1'b1;
              else            done_q <= 1'b1;
            end else begin
              mode_q <= next_mode(mode_q);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.set_time  = pulse && (sel_q == BTN_SET_TIME);
  assign bus.secondSet = pulse && (sel_q == BTN_SEC);
  assign bus.minuteSet = pulse && (sel_q == BTN_MIN);
  assign bus.hourSet   = pulse && (sel_q == BTN_HOUR);
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule
